// File: rtl/alu_share_ctrl_pkg.sv
// Shared types for the ALU sharing controller: ALU op encoding,
// controller state encoding and the default datapath width.
package alu_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } share_state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester-side bus of the ALU sharing controller: per-requester
// valid/ready request channel plus the broadcast one-hot response.
interface alu_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = alu_pkg::WIDTH_DEF
);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][1:0]       req_op;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0]            resp_valid;
  logic [WIDTH-1:0]            resp_data;
  logic                        resp_err;

  // Requester side
  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  // Controller side
  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/alu_share_ctrl_rr_grant.sv
// Round-robin grant: one-hot select of the first valid requester at or
// above rr_ptr, wrapping modulo N_REQ. Purely combinational.
module rr_grant #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant
);

  int   idx;
  logic found;

  // Scan upward from the pointer and keep the first hit
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one ALU between N_REQ requesters.
// Round-robin grant in IDLE, one-cycle issue strobe, wait for the ALU
// result, one-cycle one-hot response to the owner, then back to IDLE.
// Optional feature macro: ALU_SHARE_TIMEOUT_EN -- bounds the WAIT state
// to TIMEOUT cycles and answers with resp_err = 1, resp_data = 0.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_in_valid,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_out_valid,
  output logic             busy
);

  localparam int PTR_W = $clog2(N_REQ);

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("alu_share_ctrl: TIMEOUT must be at least 1");
  end

  share_state_e     state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] grant_idx;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic             hs;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] cur);
    if (int'(cur) == N_REQ - 1) return '0;
    return cur + PTR_W'(1);
  endfunction

  rr_grant #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr_grant (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant)
  );

  assign bus.req_ready  = (state == ST_IDLE) ? grant : '0;
  assign hs             = |(bus.req_valid & bus.req_ready);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign busy           = (state != ST_IDLE);

  // One-hot grant to requester index
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) grant_idx = PTR_W'(i);
    end
  end

`ifdef ALU_SHARE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;
  logic             resp_err_q;
  logic             tmo_hit;

  // Counter holds TIMEOUT-1 during the last allowed WAIT cycle
  assign tmo_hit      = (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign bus.resp_err = resp_err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  // Sequencer FSM with registered ALU issue and response outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      alu_in_valid <= 1'b0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
`ifdef ALU_SHARE_TIMEOUT_EN
      tmo_cnt      <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      alu_in_valid <= 1'b0;
      resp_valid_q <= '0;
      unique case (state)
        ST_IDLE: begin
          if (hs) begin
            owner        <= grant_idx;
            alu_op       <= bus.req_op[grant_idx];
            alu_a        <= bus.req_a[grant_idx];
            alu_b        <= bus.req_b[grant_idx];
            alu_in_valid <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef ALU_SHARE_TIMEOUT_EN
          tmo_cnt <= '0;
`endif
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          if (alu_out_valid) begin
            resp_data_q  <= alu_out;
            resp_valid_q <= N_REQ'(1) << owner;
`ifdef ALU_SHARE_TIMEOUT_EN
            resp_err_q   <= 1'b0;
`endif
            state        <= ST_RESP;
          end
`ifdef ALU_SHARE_TIMEOUT_EN
          else if (tmo_hit) begin
            resp_data_q  <= '0;
            resp_valid_q <= N_REQ'(1) << owner;
            resp_err_q   <= 1'b1;
            state        <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        ST_RESP: begin
          rr_ptr <= next_ptr(owner);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Testbench for alu_share_ctrl: 1-cycle ALU model, scoreboard of expected
// responses filled at each handshake and drained on each resp_valid.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int N_REQ   = 4;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic             alu_in_valid;
  logic [WIDTH-1:0] alu_out = '0;
  logic             alu_out_valid = 1'b0;
  logic             busy;
  logic             alu_mute = 1'b0;
  logic             alu_inject = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
    logic             err;
    int               lat;
  } exp_t;

  exp_t sb_q[$];
  int   exp_grant_q[$];
  exp_t e_push, e_pop;
  int   gi;
  int   hs_cyc = 0;
  int   prev_hs_cyc = -1;
  int   hs_count = 0;
  int   resp_count = 0;
  bit   chk_spacing = 1'b0;
  bit   tmo_mode = 1'b0;
  logic [1:0]       hs_op;
  logic [WIDTH-1:0] hs_a, hs_b;
  logic [WIDTH-1:0] last_resp_data = '0;
  logic             last_resp_err = 1'b0;

  alu_share_ctrl_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

  alu_share_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_in_valid  (alu_in_valid),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WIDTH-1:0] alu_model(input logic [1:0] op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    case (alu_op_e'(op))
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      default: return a | b;
    endcase
  endfunction

  function automatic int onehot_idx(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Bench ALU: one-cycle latency, can be muted or forced to emit a stray result
  always @(posedge clk) begin
    alu_out_valid <= (alu_in_valid && !alu_mute) || alu_inject;
    alu_out       <= alu_model(alu_op, alu_a, alu_b);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Monitor on the falling edge: handshakes push, responses pop
  always @(negedge clk) begin
    if (!rst) begin
      sb_q.delete();
    end else begin
      if (|(bus.req_valid & bus.req_ready)) begin
        gi = onehot_idx(bus.req_ready);
        check_eq("ready_onehot", 32'($onehot(bus.req_ready)), 1);
        if (exp_grant_q.size() > 0) check_eq("grant", gi, exp_grant_q.pop_front());
        else check_eq("grant_unplanned", gi, 99);
        if (chk_spacing && prev_hs_cyc >= 0) check_eq("issue_spacing", cyc - prev_hs_cyc, 4);
        hs_op = bus.req_op[gi];
        hs_a  = bus.req_a[gi];
        hs_b  = bus.req_b[gi];
        e_push.idx  = gi;
        e_push.data = tmo_mode ? '0 : alu_model(hs_op, hs_a, hs_b);
        e_push.err  = tmo_mode;
        e_push.lat  = tmo_mode ? TIMEOUT + 2 : 3;
        sb_q.push_back(e_push);
        hs_cyc      = cyc;
        prev_hs_cyc = cyc;
        hs_count++;
      end
      if (alu_in_valid) begin
        check_eq("issue_lat", cyc - hs_cyc, 1);
        check_eq("issue_op", alu_op, hs_op);
        check_eq("issue_a", alu_a, hs_a);
        check_eq("issue_b", alu_b, hs_b);
      end
      if (bus.resp_valid != '0) begin
        resp_count++;
        last_resp_data = bus.resp_data;
        last_resp_err  = bus.resp_err;
        if (sb_q.size() == 0) begin
          check_eq("resp_unexpected", bus.resp_valid, 0);
        end else begin
          e_pop = sb_q.pop_front();
          check_eq("resp_strobe", bus.resp_valid, 32'(1) << e_pop.idx);
          check_eq("resp_data", bus.resp_data, e_pop.data);
          check_eq("resp_err", bus.resp_err, e_pop.err);
          check_eq("resp_lat", cyc - hs_cyc, e_pop.lat);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic [1:0] op,
                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req_valid[i] = 1'b1;
    bus.req_op[i]    = op;
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
  endtask

  task automatic clr_all();
    bus.req_valid = '0;
  endtask

  task automatic wait_hs(input int target, input int bound);
    int n = 0;
    while (hs_count < target && n < bound) begin
      step();
      n++;
    end
    check_eq("hs_wait", 32'(hs_count >= target), 1);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < bound) begin
      step();
      n++;
    end
    check_eq("drain", 32'(sb_q.size() == 0 && !busy), 1);
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int rc;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;

    // Reset: two cycles low, then everything idle and zero
    rst = 1'b0;
    step();
    step();
    check_eq("rst_req_ready", bus.req_ready, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_resp_data", bus.resp_data, 0);
    check_eq("rst_resp_err", bus.resp_err, 0);
    check_eq("rst_alu_in_valid", alu_in_valid, 0);
    check_eq("rst_alu_op", alu_op, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_alu_b", alu_b, 0);
    check_eq("rst_busy", busy, 0);
    rst = 1'b1;
    step();

    // Single request: requester 0, 9 - 6
    req(0, OP_SUB, 4'd9, 4'd6);
    exp_grant_q.push_back(0);
    wait_hs(hs_count + 1, 20);
    clr_all();
    drain(20);
    check_eq("single_data", last_resp_data, 3);

    // Round-robin fairness from a fresh pointer
    reset_dut();
    for (int i = 0; i < N_REQ; i++) req(i, OP_ADD, 4'd1, 4'd3);
    exp_grant_q.push_back(0);
    exp_grant_q.push_back(1);
    exp_grant_q.push_back(2);
    exp_grant_q.push_back(3);
    exp_grant_q.push_back(0);
    prev_hs_cyc = -1;
    chk_spacing = 1'b1;
    wait_hs(hs_count + 5, 60);
    clr_all();
    drain(20);
    chk_spacing = 1'b0;
    check_eq("rr_data", last_resp_data, 4);
    check_eq("rr_grants_left", exp_grant_q.size(), 0);

    // Wrap and overflow: requester 3 alone, 15 + 1
    req(3, OP_ADD, 4'd15, 4'd1);
    exp_grant_q.push_back(3);
    wait_hs(hs_count + 1, 20);
    clr_all();
    drain(20);
    check_eq("wrap_data", last_resp_data, 0);
    // Pointer is now 0: requester 1 beats requester 3
    req(1, OP_AND, 4'd12, 4'd10);
    req(3, OP_OR, 4'd1, 4'd2);
    exp_grant_q.push_back(1);
    wait_hs(hs_count + 1, 20);
    clr_all();
    drain(20);
    check_eq("wrap_next_data", last_resp_data, 8);

    // Reset while waiting on the ALU
    req(1, OP_ADD, 4'd2, 4'd2);
    exp_grant_q.push_back(1);
    wait_hs(hs_count + 1, 20);
    clr_all();
    step();
    check_eq("busy_in_wait", busy, 1);
    rc = resp_count;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check_eq("rst_no_resp", resp_count, rc);
    check_eq("rst_busy_after", busy, 0);
    req(2, OP_OR, 4'd5, 4'd10);
    exp_grant_q.push_back(2);
    wait_hs(hs_count + 1, 20);
    clr_all();
    drain(20);
    check_eq("post_rst_data", last_resp_data, 15);

`ifdef ALU_SHARE_TIMEOUT_EN
    // ALU never answers: error response after TIMEOUT wait cycles
    alu_mute = 1'b1;
    tmo_mode = 1'b1;
    req(0, OP_ADD, 4'd3, 4'd3);
    exp_grant_q.push_back(0);
    wait_hs(hs_count + 1, 20);
    clr_all();
    tmo_mode = 1'b0;
    drain(TIMEOUT + 20);
    check_eq("tmo_err", last_resp_err, 1);
    check_eq("tmo_data", last_resp_data, 0);
    // Stray late result while idle must not produce a response
    rc = resp_count;
    alu_inject = 1'b1;
    step();
    alu_inject = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_eq("late_no_resp", resp_count, rc);
    alu_mute = 1'b0;
    req(1, OP_SUB, 4'd4, 4'd7);
    exp_grant_q.push_back(1);
    wait_hs(hs_count + 1, 20);
    clr_all();
    drain(20);
    check_eq("tmo_recover_err", last_resp_err, 0);
    check_eq("tmo_recover_data", last_resp_data, 13);
`endif

    check_eq("sb_empty_end", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and round-robin arbiter sharing one ALU between `N_REQ` requesters. Each requester presents an op and two operands on a valid/ready handshake. The block grants one requester at a time, issues the op to the ALU and waits for the ALU's `out_valid`. It then routes the result back to the granted requester with a one-hot response strobe. The block sits between the lab's request sources (keypad/switch front-ends, test sequencers) and the single shared `alu` instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 4, operand/result width
- `TIMEOUT`, 15, maximum WAIT cycles before error response (used only with the timeout feature)

- `clk` in 1: single clock, all logic on rising edge
- `rst` in 1: synchronous, active-low reset (0 = reset)
- `req_valid` in N_REQ: per-requester request
- `req_ready` out N_REQ: per-requester accept, at most one bit high
- `req_op` in N_REQ×2: per-requester ALU op
- `req_a`, `req_b` in N_REQ×WIDTH: per-requester operands
- `resp_valid` out N_REQ: one-hot result strobe, one cycle, no backpressure
- `resp_data` out WIDTH: result, valid with `resp_valid`
- `resp_err` out 1: result timed out, valid with `resp_valid`
- `alu_op` out 2, `alu_a`/`alu_b` out WIDTH: ALU inputs, registered
- `alu_in_valid` out 1: one-cycle issue strobe
- `alu_out` in WIDTH, `alu_out_valid` in 1: ALU result
- `busy` out 1: FSM not in IDLE

## Operation
- FSM states: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - Grant is the first `req_valid` bit at or after `rr_ptr`, scanning upward modulo N_REQ.
  - `req_ready[grant]` = 1 combinationally.
  - On `req_valid & req_ready`, capture op/a/b and owner index, then go to ISSUE.
  - No valid requests: stay in IDLE; all `req_ready` = 0.
- ISSUE: drive `alu_in_valid` = 1 for exactly one cycle with the captured operands, then go to WAIT.
- WAIT: on `alu_out_valid`, capture `alu_out` into `resp_data`, `resp_err` = 0, go to RESP.
- RESP:
  - `resp_valid[owner]` = 1 for one cycle.
  - `rr_ptr` ← (owner+1) mod N_REQ.
  - Go to IDLE.
- `alu_op`/`alu_a`/`alu_b` hold their last issued values outside ISSUE.
- `alu_out_valid` is ignored in IDLE, ISSUE and RESP.
- A requester that drops `req_valid` before its handshake is simply not granted. No requester is granted twice while another is waiting.
- The ALU delivers at most one `out_valid` per `in_valid`.

## Timing
- Reset values:
  - FSM = IDLE, `rr_ptr` = 0.
  - All `req_ready`, `resp_valid`, `alu_in_valid` = 0.
  - `resp_data`, `resp_err`, `alu_op`, `alu_a`, `alu_b` = 0.
  - `busy` = 0.
- Handshake edge = cycle 0. `alu_in_valid` is high in cycle 1.
- With a 1-cycle ALU, `alu_out_valid` arrives in cycle 2 and `resp_valid` is high in cycle 3. The next grant is possible in cycle 4.
- Minimum issue-to-issue spacing is 4 cycles.
- Reset asserted in any state:
  - Return to IDLE next edge.
  - The in-flight op is discarded and no `resp_valid` is produced.
  - `rr_ptr` = 0.
- Wrap-around: owner N_REQ−1 sets `rr_ptr` = 0.
- A new request arriving in RESP waits until IDLE.

## Configuration
- Macro: `ALU_SHARE_TIMEOUT_EN`.
- Defined:
  - A `$clog2(TIMEOUT+1)`-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - After TIMEOUT WAIT cycles without `alu_out_valid`, go to RESP with `resp_data` = 0 and `resp_err` = 1.
  - `alu_out_valid` and timeout in the same cycle: the result wins, `resp_err` = 0.
  - A late result for a timed-out op arrives in IDLE or ISSUE and is discarded.
- Undefined: no counter; WAIT holds indefinitely; `resp_err` is tied to 0.

## Structure
- Package `alu_pkg`:
  - `alu_op_e`: 2'b00 ADD, 2'b01 SUB, 2'b10 AND, 2'b11 OR (opaque to this block, used by the bench ALU model).
  - State enum `share_state_e`.
  - Default `WIDTH` constant.
- Sub-module `rr_grant`: combinational one-hot grant from `req_valid` and `rr_ptr`, parameterised on N_REQ.

## Test plan
Bench ALU model: 1-cycle latency, ops per `alu_op_e`.
- Reset: hold `rst` = 0 for 2 cycles → all outputs 0, `busy` = 0.
- Single request: requester 0 sends SUB, a = 9, b = 6 → `alu_in_valid` one cycle later; `resp_valid` = 4'b0001 with `resp_data` = 3, 3 cycles after handshake.
- Round-robin fairness:
  - All four requesters hold ADD 1+3 continuously.
  - Expect grants 0, 1, 2, 3, 0, one every 4 cycles.
  - Expect every `resp_data` = 4.
- Wrap and overflow: requester 3 only, ADD a = 15, b = 1 → `resp_data` = 0; `rr_ptr` wraps to 0 and a following requester-1 request is granted next.
- Reset mid-WAIT: assert `rst` while in WAIT → no `resp_valid`; next request from requester 2 is served normally.
- Timeout (macro defined): ALU model never answers → `resp_valid` after TIMEOUT WAIT cycles with `resp_err` = 1 and `resp_data` = 0. A late `alu_out_valid` in IDLE produces no response.
